// File: rtl/uart_rx_bit_timer.sv
// Bit/frame timing engine for the UART receiver: configurable frame format,
// 3-point mid-bit sample strobes, bit/frame completion pulses, illegal-config flag.
module uart_rx_bit_timer #(
    parameter int PRESCALE_W = 6,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic [3:0]            data_bits_i,
    input  logic                  parity_en_i,
    input  logic                  stop2_i,
    output logic [PRESCALE_W-1:0] edge_cnt_o,
    output logic [CNT_W-1:0]      bit_cnt_o,
    output logic                  sample_strobe_o,
    output logic [1:0]            sample_idx_o,
    output logic                  bit_tick_o,
    output logic                  frame_last_o,
    output logic                  frame_done_o,
    output logic                  cfg_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [PRESCALE_W-1:0]   p_q, p_d;
    logic [3:0]              d_q, d_d;
    logic                    pe_q, pe_d;
    logic                    s2_q, s2_d;
    logic [PRESCALE_W-1:0]   edge_q, edge_d;
    logic [CNT_W-1:0]        bit_q, bit_d;

    logic                    run;
    logic                    cfg_legal;
    logic [CNT_W-1:0]        frame_len;
    logic [PRESCALE_W-1:0]   mid;
    logic                    last_edge;
    logic                    last_bit;
    logic                    bit_tick;
    logic                    frame_done;

    assign run       = (state_q == RUN);
    assign cfg_legal = (prescale_i >= PRESCALE_W'(4)) &&
                       (data_bits_i >= 4'd5) && (data_bits_i <= 4'd9);

    // Frame length covers start + data + optional parity + 1 or 2 stop bits.
    assign frame_len  = CNT_W'(1) + CNT_W'(d_q) + CNT_W'(pe_q) +
                        (s2_q ? CNT_W'(2) : CNT_W'(1));
    assign mid        = p_q >> 1;
    assign last_edge  = (edge_q == p_q - PRESCALE_W'(1));
    assign last_bit   = (bit_q == frame_len - CNT_W'(1));
    assign bit_tick   = run && last_edge;
    assign frame_done = bit_tick && last_bit;

    assign edge_cnt_o   = edge_q;
    assign bit_cnt_o    = bit_q;
    assign bit_tick_o   = bit_tick;
    assign frame_done_o = frame_done;
    assign frame_last_o = run && last_bit;
    assign cfg_err_o    = (state_q == ERR);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sample_strobe_o = 1'b0;
        sample_idx_o    = 2'd0;
        if (run) begin
            if (edge_q == mid - PRESCALE_W'(1)) begin
                sample_strobe_o = 1'b1;
                sample_idx_o    = 2'd0;
            end else if (edge_q == mid) begin
                sample_strobe_o = 1'b1;
                sample_idx_o    = 2'd1;
            end else if (edge_q == mid + PRESCALE_W'(1)) begin
                sample_strobe_o = 1'b1;
                sample_idx_o    = 2'd2;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        d_d     = d_q;
        pe_d    = pe_q;
        s2_d    = s2_q;
        edge_d  = edge_q;
        bit_d   = bit_q;

        unique case (state_q)
            IDLE: begin
                edge_d = '0;
                bit_d  = '0;
                if (enable_i) begin
                    p_d     = prescale_i;
                    d_d     = data_bits_i;
                    pe_d    = parity_en_i;
                    s2_d    = stop2_i;
                    state_d = cfg_legal ? RUN : ERR;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    state_d = IDLE;
                    edge_d  = '0;
                    bit_d   = '0;
                end else if (frame_done) begin
                    // Re-latch at the frame boundary so the next frame starts with no gap.
                    p_d     = prescale_i;
                    d_d     = data_bits_i;
                    pe_d    = parity_en_i;
                    s2_d    = stop2_i;
                    state_d = cfg_legal ? RUN : ERR;
                    edge_d  = '0;
                    bit_d   = '0;
                end else if (bit_tick) begin
                    edge_d = '0;
                    bit_d  = bit_q + CNT_W'(1);
                end else begin
                    edge_d = edge_q + PRESCALE_W'(1);
                end
            end
            ERR: begin
                edge_d = '0;
                bit_d  = '0;
                if (!enable_i) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                edge_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            d_q     <= '0;
            pe_q    <= 1'b0;
            s2_q    <= 1'b0;
            edge_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            d_q     <= d_d;
            pe_q    <= pe_d;
            s2_q    <= s2_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Self-checking bench for uart_rx_bit_timer: expected frame results are queued
// at stimulus time and compared when the DUT pulses frame_done.
module tb_uart_rx_bit_timer;

    localparam int PW = 6;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [PW-1:0] prescale;
    logic [3:0]    data_bits;
    logic          parity_en;
    logic          stop2;
    logic [PW-1:0] edge_cnt;
    logic [CW-1:0] bit_cnt;
    logic          sample_strobe;
    logic [1:0]    sample_idx;
    logic          bit_tick;
    logic          frame_last;
    logic          frame_done;
    logic          cfg_err;

    uart_rx_bit_timer #(.PRESCALE_W(PW), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable_i        (enable),
        .prescale_i      (prescale),
        .data_bits_i     (data_bits),
        .parity_en_i     (parity_en),
        .stop2_i         (stop2),
        .edge_cnt_o      (edge_cnt),
        .bit_cnt_o       (bit_cnt),
        .sample_strobe_o (sample_strobe),
        .sample_idx_o    (sample_idx),
        .bit_tick_o      (bit_tick),
        .frame_last_o    (frame_last),
        .frame_done_o    (frame_done),
        .cfg_err_o       (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int done_rel;
        int ticks;
        int strobes;
        int last_first;
        int max_bit;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int origin   = 0;
    int exp_mid  = 0;
    int acc_ticks, acc_strobes, acc_last_first, acc_max_bit;

    logic [16:0] outs;
    assign outs = {edge_cnt, bit_cnt, sample_strobe, sample_idx, bit_tick,
                   frame_last, frame_done, cfg_err};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_acc();
        acc_ticks      = 0;
        acc_strobes    = 0;
        acc_last_first = 0;
        acc_max_bit    = 0;
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Expected results of one frame of L bits at prescale P that starts at rel cycle off+1.
    task automatic push_frame(input int p, input int l, input int off);
        exp_t e;
        e.done_rel   = off + p * l;
        e.ticks      = l;
        e.strobes    = 3 * l;
        e.last_first = off + p * (l - 1) + 1;
        e.max_bit    = l - 1;
        sb.push_back(e);
    endtask

    task automatic start_frame(input int p, input int d, input logic pe, input logic s2);
        prescale  = PW'(p);
        data_bits = 4'(d);
        parity_en = pe;
        stop2     = s2;
        enable    = 1'b1;
        origin    = cyc;
        exp_mid   = p >> 1;
        clear_acc();
    endtask

    task automatic wait_sb(input string tag, input int left, input int budget);
        int k = 0;
        while (sb.size() > left && k < budget) begin
            step();
            k++;
        end
        if (sb.size() > left) begin
            check({"timeout_", tag}, sb.size(), left);
            sb.delete();
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sample_strobe) begin
            check("strobe_pos", int'(edge_cnt) - (exp_mid - 1), 32'(sample_idx));
            acc_strobes++;
        end
        if (bit_tick) acc_ticks++;
        if (frame_last && acc_last_first == 0) acc_last_first = cyc - origin;
        if (int'(bit_cnt) > acc_max_bit) acc_max_bit = int'(bit_cnt);
        if (frame_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", cyc - origin, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", cyc - origin, e.done_rel);
                check("tick_count", acc_ticks, e.ticks);
                check("strobe_count", acc_strobes, e.strobes);
                check("last_first", acc_last_first, e.last_first);
                check("max_bit", acc_max_bit, e.max_bit);
            end
            clear_acc();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    typedef struct { int p; int d; } bad_cfg_t;
    bad_cfg_t bad_cfgs[3] = '{'{3, 8}, '{8, 10}, '{8, 4}};

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        prescale  = 8;
        data_bits = 8;
        parity_en = 1'b0;
        stop2     = 1'b0;
        clear_acc();
        step(2);
        check("reset_outs", 32'(outs), 0);
        rst = 1'b0;
        step();
        check("idle_outs", 32'(outs), 0);

        // P=8 D=8 one stop: L=10
        push_frame(8, 10, 0);
        start_frame(8, 8, 1'b0, 1'b0);
        wait_sb("p8d8", 0, 200);
        enable = 1'b0;
        step();
        check("p8d8_idle", 32'(outs), 0);

        // P=16 D=9 parity, two stop: L=13
        push_frame(16, 13, 0);
        start_frame(16, 9, 1'b1, 1'b1);
        wait_sb("p16d9", 0, 400);
        enable = 1'b0;
        step();
        check("p16d9_idle", 32'(outs), 0);

        // Back-to-back: D=5 (L=7), D changed to 6 mid-frame -> second frame L=8
        push_frame(8, 7, 0);
        push_frame(8, 8, 56);
        start_frame(8, 5, 1'b0, 1'b0);
        step(10);
        data_bits = 6;
        wait_sb("b2b_first", 1, 200);
        step();
        check("b2b_edge0", 32'(edge_cnt), 0);
        check("b2b_bit0", 32'(bit_cnt), 0);
        step();
        check("b2b_edge1", 32'(edge_cnt), 1);
        wait_sb("b2b_second", 0, 200);
        enable = 1'b0;
        step();
        check("b2b_idle", 32'(outs), 0);

        // Enable dropped mid-frame, then restart from bit 0
        start_frame(8, 8, 1'b0, 1'b0);
        step(36);
        check("drop_bit", 32'(bit_cnt), 4);
        check("drop_edge", 32'(edge_cnt), 3);
        enable = 1'b0;
        step();
        check("drop_idle", 32'(outs), 0);
        push_frame(8, 10, 0);
        start_frame(8, 8, 1'b0, 1'b0);
        wait_sb("restart", 0, 200);
        enable = 1'b0;
        step();

        // Illegal configurations
        foreach (bad_cfgs[i]) begin
            start_frame(bad_cfgs[i].p, bad_cfgs[i].d, 1'b0, 1'b0);
            step(20);
            check("bad_cfg_err", 32'(cfg_err), 1);
            check("bad_no_strobe", acc_strobes, 0);
            check("bad_no_tick", acc_ticks, 0);
            check("bad_edge", 32'(edge_cnt), 0);
            enable = 1'b0;
            step();
            check("bad_clear", 32'(outs), 0);
        end

        // Legal frame followed by an illegal re-latch at the frame boundary
        push_frame(8, 7, 0);
        start_frame(8, 5, 1'b0, 1'b0);
        step(5);
        prescale = 3;
        wait_sb("relatch", 0, 200);
        step();
        check("relatch_err", 32'(cfg_err), 1);
        enable = 1'b0;
        step();
        check("relatch_clear", 32'(cfg_err), 0);

        // Reset mid-frame with enable held high
        start_frame(8, 8, 1'b0, 1'b0);
        step(54);
        check("rst_pre_bit", 32'(bit_cnt), 6);
        check("rst_pre_edge", 32'(edge_cnt), 5);
        rst = 1'b1;
        step();
        check("rst_outs", 32'(outs), 0);
        rst = 1'b0;
        origin = cyc;
        clear_acc();
        push_frame(8, 10, 0);
        step();
        check("rst_fresh_edge", 32'(edge_cnt), 0);
        wait_sb("after_rst", 0, 200);
        enable = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
